// File: rtl/td4_pkg.sv
// TD4 sequencer shared definitions: FSM state encoding, ALU source
// select codes and 4-bit opcode constants used by decode and bench.
package td4_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2
   } state_e;

   localparam logic [1:0] SEL_A    = 2'b00;
   localparam logic [1:0] SEL_B    = 2'b01;
   localparam logic [1:0] SEL_IN   = 2'b10;
   localparam logic [1:0] SEL_ZERO = 2'b11;

   localparam logic [3:0] OP_ADD_A = 4'h0;
   localparam logic [3:0] OP_MOV_AB = 4'h1;
   localparam logic [3:0] OP_IN_A  = 4'h2;
   localparam logic [3:0] OP_MOV_AI = 4'h3;
   localparam logic [3:0] OP_MOV_BA = 4'h4;
   localparam logic [3:0] OP_ADD_B = 4'h5;
   localparam logic [3:0] OP_IN_B  = 4'h6;
   localparam logic [3:0] OP_MOV_BI = 4'h7;
   localparam logic [3:0] OP_OUT_B = 4'h9;
   localparam logic [3:0] OP_OUT_I = 4'hB;
   localparam logic [3:0] OP_JNC   = 4'hE;
   localparam logic [3:0] OP_JMP   = 4'hF;

endpackage

// File: rtl/td4_decode.sv
// TD4 opcode decoder (combinational). Ports: op (ir[7:4]), cflag in;
// sel, ld_a_n, ld_b_n, ld_out_n, pc_ld_n out. Ungated by FSM state.
module td4_decode
   import td4_pkg::*;
(
   input  logic [3:0] op,
   input  logic       cflag,
   output logic [1:0] sel,
   output logic       ld_a_n,
   output logic       ld_b_n,
   output logic       ld_out_n,
   output logic       pc_ld_n
);

   always_comb begin
      sel      = SEL_ZERO;
      ld_a_n   = 1'b1;
      ld_b_n   = 1'b1;
      ld_out_n = 1'b1;
      pc_ld_n  = 1'b1;
      unique case (op)
         OP_ADD_A:  begin sel = SEL_A;    ld_a_n = 1'b0; end
         OP_MOV_AB: begin sel = SEL_B;    ld_a_n = 1'b0; end
         OP_IN_A:   begin sel = SEL_IN;   ld_a_n = 1'b0; end
         OP_MOV_AI: begin sel = SEL_ZERO; ld_a_n = 1'b0; end
         OP_MOV_BA: begin sel = SEL_A;    ld_b_n = 1'b0; end
         OP_ADD_B:  begin sel = SEL_B;    ld_b_n = 1'b0; end
         OP_IN_B:   begin sel = SEL_IN;   ld_b_n = 1'b0; end
         OP_MOV_BI: begin sel = SEL_ZERO; ld_b_n = 1'b0; end
         OP_OUT_B:  begin sel = SEL_B;    ld_out_n = 1'b0; end
         OP_OUT_I:  begin sel = SEL_ZERO; ld_out_n = 1'b0; end
         OP_JNC:    pc_ld_n = cflag;
         OP_JMP:    pc_ld_n = 1'b0;
         default:   ;
      endcase
   end

endmodule

// File: rtl/td4_seq.sv
// TD4 sequencer: IDLE/FETCH/EXEC FSM, instruction and carry registers.
// Ports: clk, reset (async, low), run, instr[7:0], carry_in in;
// pc_ce, pc_ld_n, ld_a_n, ld_b_n, ld_out_n, sel[1:0], imm[3:0], cflag,
// halted out. Macro TD4_STEP_EN adds step (in) and step_done (out).
module td4_seq
   import td4_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
`ifdef TD4_STEP_EN
   input  logic       step,
   output logic       step_done,
`endif
   input  logic       run,
   input  logic [7:0] instr,
   input  logic       carry_in,
   output logic       pc_ce,
   output logic       pc_ld_n,
   output logic       ld_a_n,
   output logic       ld_b_n,
   output logic       ld_out_n,
   output logic [1:0] sel,
   output logic [3:0] imm,
   output logic       cflag,
   output logic       halted
);

   state_e     state_q, state_d;
   logic [7:0] ir_q;
   logic       cflag_q;
   logic       start;

   logic [1:0] dec_sel;
   logic       dec_a_n, dec_b_n, dec_o_n, dec_pc_n;
   logic       exec;

`ifdef TD4_STEP_EN
   logic step_s_q, step_p_q, stepping_q;
   logic step_go;

   // One sync flop, then a delayed copy for rising-edge detect.
   assign step_go = step_s_q & ~step_p_q & ~run
                    & (state_q == ST_IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         step_s_q   <= 1'b0;
         step_p_q   <= 1'b0;
         stepping_q <= 1'b0;
      end else begin
         step_s_q <= step;
         step_p_q <= step_s_q;
         if (step_go)
            stepping_q <= 1'b1;
         else if (state_q == ST_EXEC)
            stepping_q <= 1'b0;
      end
   end

   assign step_done = exec & stepping_q;
   assign start     = run | step_go;
`else
   assign start = run;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start) state_d = ST_FETCH;
         ST_FETCH: state_d = ST_EXEC;
         ST_EXEC:  state_d = run ? ST_FETCH : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         ir_q    <= 8'h00;
         cflag_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_FETCH)
            ir_q <= instr;
         if (state_q == ST_EXEC)
            cflag_q <= carry_in;
      end
   end

   td4_decode u_dec (
      .op       (ir_q[7:4]),
      .cflag    (cflag_q),
      .sel      (dec_sel),
      .ld_a_n   (dec_a_n),
      .ld_b_n   (dec_b_n),
      .ld_out_n (dec_o_n),
      .pc_ld_n  (dec_pc_n)
   );

   // Strobes are gated by the state register, so an async reset
   // drops them immediately without waiting for a clock.
   assign exec     = (state_q == ST_EXEC);
   assign pc_ce    = exec;
   assign pc_ld_n  = ~exec | dec_pc_n;
   assign ld_a_n   = ~exec | dec_a_n;
   assign ld_b_n   = ~exec | dec_b_n;
   assign ld_out_n = ~exec | dec_o_n;
   assign sel      = exec ? dec_sel : SEL_ZERO;
   assign imm      = ir_q[3:0];
   assign cflag    = cflag_q;
   assign halted   = (state_q == ST_IDLE);

endmodule
